// File: rtl/k_dp_sync_fifo.sv
// Single-clock FIFO on a 2**ADDR_W dual-port RAM; registered read data one clk after rd_en; full/empty refuse requests.
// Optional sticky overflow/underflow error ports when K_FIFO_ERR_EN is defined.
module k_dp_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int AFULL_TH  = 3,
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count
`ifdef K_FIFO_ERR_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              wr_acc, rd_acc;

  // Acceptance uses only the registered flags, so full+wr+rd drops the write.
  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (ADDR_W+1)'(wr_acc);
    rd_ptr_d   = rd_ptr_q + (ADDR_W+1)'(rd_acc);
    count_d    = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    rd_valid_d = rd_acc;
    rd_data_d  = rd_data_q;
    if (rd_acc) begin
      rd_data_d = mem[rd_ptr_q[ADDR_W-1:0]];
    end
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
               (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

  // Storage is not reset; a same-address read in this cycle sees the old word.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;

`ifdef K_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr_en && full_q);
    underflow_d = underflow_q | (rd_en && empty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_k_dp_sync_fifo.sv
// Directed bench for k_dp_sync_fifo; expected read words are queued at issue and checked by a monitor.
module tb_k_dp_sync_fifo;
  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
`ifdef K_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  k_dp_sync_fifo #(.DATA_W(8), .ADDR_W(2), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef K_FIFO_ERR_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic [2:0] c, input logic f,
                           input logic e, input logic af, input logic ae);
    chk({name, "_count"}, 32'(count), 32'(c));
    chk({name, "_full"}, 32'(full), 32'(f));
    chk({name, "_empty"}, 32'(empty), 32'(e));
    chk({name, "_afull"}, 32'(almost_full), 32'(af));
    chk({name, "_aempty"}, 32'(almost_empty), 32'(ae));
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got rd_data %0h expected no read", rd_data);
      end else begin
        chk("sb_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  logic [7:0] t4_exp [10] = '{8'h21, 8'h22, 8'h10, 8'h11, 8'h12,
                              8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  logic [7:0] fill4 [4]   = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset/idle
    cyc(0, 8'h00, 0);
    chk_flags("t1", 3'd0, 0, 1, 0, 1);
    chk("t1_rd_valid", 32'(rd_valid), 32'd0);
    chk("t1_rd_data", 32'(rd_data), 32'h00);

    // 2: fill then overflow attempt
    cyc(1, fill4[0], 0);
    chk_flags("t2_w1", 3'd1, 0, 0, 0, 1);
    cyc(1, fill4[1], 0);
    chk_flags("t2_w2", 3'd2, 0, 0, 0, 0);
    cyc(1, fill4[2], 0);
    chk_flags("t2_w3", 3'd3, 0, 0, 1, 0);
    cyc(1, fill4[3], 0);
    chk_flags("t2_w4", 3'd4, 1, 0, 1, 0);
    cyc(1, 8'hFF, 0);
    chk_flags("t2_w5", 3'd4, 1, 0, 1, 0);
`ifdef K_FIFO_ERR_EN
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_underflow", 32'(underflow), 32'd0);
`endif

    // 3: drain, then underflow attempt
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(fill4[i]);
      cyc(0, 8'h00, 1);
      chk("t3_rd_valid", 32'(rd_valid), 32'd1);
    end
    chk_flags("t3_drained", 3'd0, 0, 1, 0, 1);
    cyc(0, 8'h00, 1);
    chk("t3_rd5_valid", 32'(rd_valid), 32'd0);
    chk("t3_rd5_hold", 32'(rd_data), 32'hA4);
`ifdef K_FIFO_ERR_EN
    chk("t3_underflow", 32'(underflow), 32'd1);
`endif

    // 4: steady-state simultaneous read/write at count=2
    cyc(1, 8'h21, 0);
    cyc(1, 8'h22, 0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(t4_exp[i]);
      cyc(1, 8'h10 + 8'(i), 1);
      chk("t4_count", 32'(count), 32'd2);
    end
    exp_q.push_back(8'h18);
    cyc(0, 8'h00, 1);
    exp_q.push_back(8'h19);
    cyc(0, 8'h00, 1);
    chk_flags("t4_drained", 3'd0, 0, 1, 0, 1);

    // 5a: full with simultaneous wr/rd drops the write
    cyc(1, 8'h31, 0);
    cyc(1, 8'h32, 0);
    cyc(1, 8'h33, 0);
    cyc(1, 8'h34, 0);
    chk("t5_full", 32'(full), 32'd1);
    exp_q.push_back(8'h31);
    cyc(1, 8'h3F, 1);
    chk_flags("t5_full_wr_rd", 3'd3, 0, 0, 1, 0);
    exp_q.push_back(8'h32);
    cyc(0, 8'h00, 1);
    exp_q.push_back(8'h33);
    cyc(0, 8'h00, 1);
    exp_q.push_back(8'h34);
    cyc(0, 8'h00, 1);
    chk_flags("t5_drained", 3'd0, 0, 1, 0, 1);

    // 5b: empty with simultaneous wr/rd drops the read
    cyc(1, 8'h4E, 1);
    chk("t5_empty_rd_valid", 32'(rd_valid), 32'd0);
    chk_flags("t5_empty_wr_rd", 3'd1, 0, 0, 0, 1);
    exp_q.push_back(8'h4E);
    cyc(0, 8'h00, 1);
    chk("t5_empty_after", 32'(empty), 32'd1);

    // 6: asynchronous reset mid-stream
    cyc(1, 8'h51, 0);
    cyc(1, 8'h52, 0);
    cyc(1, 8'h53, 0);
    chk("t6_pre_count", 32'(count), 32'd3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_flags("t6_async_rst", 3'd0, 0, 1, 0, 1);
    chk("t6_rst_rd_data", 32'(rd_data), 32'h00);
`ifdef K_FIFO_ERR_EN
    chk("t6_rst_overflow", 32'(overflow), 32'd0);
    chk("t6_rst_underflow", 32'(underflow), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'h5C, 0);
    chk("t6_count1", 32'(count), 32'd1);
    exp_q.push_back(8'h5C);
    cyc(0, 8'h00, 1);
    chk("t6_rd_valid", 32'(rd_valid), 32'd1);
    cyc(0, 8'h00, 0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
